// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StServe,
    StResp
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick with its last-grant register.
module dmem_arb_rr (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic winner
);

  logic last_grant_q;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_grant_q;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  // Reset to 1 so that port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (grant_en) begin
      last_grant_q <= winner;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port and a DMA/debug port onto one shared data memory;
// each transaction takes three cycles: grant, memory access, acknowledge.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              grant_en;
  logic              winner;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] r0_rdata_q;
  logic [DATA_W-1:0] r1_rdata_q;

  assign grant_en = (state_q == StIdle) && (r0_req || r1_req);

  dmem_arb_rr u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (r0_req),
    .req1     (r1_req),
    .grant_en (grant_en),
    .winner   (winner)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (r0_req || r1_req) state_d = StServe;
      StServe: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      if (grant_en) begin
        owner_q <= winner;
        we_q    <= winner ? r1_we    : r0_we;
        addr_q  <= winner ? r1_addr  : r0_addr;
        wdata_q <= winner ? r1_wdata : r0_wdata;
      end
      // Read data is taken at the end of the memory-access cycle.
      if (state_q == StServe && !we_q) begin
        if (owner_q) begin
          r1_rdata_q <= mem_rdata;
        end else begin
          r0_rdata_q <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    mem_write = (state_q == StServe) && we_q;
    mem_read  = (state_q == StServe) && !we_q;
    r0_ack    = (state_q == StResp) && !owner_q;
    r1_ack    = (state_q == StResp) && owner_q;
    busy      = (state_q != StIdle);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r1_ack;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, owner, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W (32),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_ack    (r0_ack),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_ack    (r1_ack),
    .r1_rdata  (r1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata),
    .owner     (owner),
    .busy      (busy)
  );

  // Environment memory: 32 words decoded from the low address bits.
  bit [31:0] tb_mem [32];
  assign mem_rdata = tb_mem[mem_addr[4:0]];
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr[4:0]] <= mem_wdata;
  end

  // Transaction-level reference: phase counts cycles left in the current transaction.
  int        m_left;
  bit        m_owner, m_last, m_we;
  bit [31:0] m_addr, m_wdata;
  bit [31:0] m_rdata [2];
  bit [31:0] m_mem [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left   = 0;
    m_owner  = 1'b0;
    m_last   = 1'b1;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step();
    bit w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_left == 0) begin
      if (r0_req || r1_req) begin
        w       = (r0_req && r1_req) ? ~m_last : r1_req;
        m_owner = w;
        m_last  = w;
        m_we    = w ? r1_we : r0_we;
        m_addr  = w ? r1_addr : r0_addr;
        m_wdata = w ? r1_wdata : r0_wdata;
        m_left  = 2;
      end
    end else if (m_left == 2) begin
      if (m_we) m_mem[m_addr[4:0]] = m_wdata;
      else m_rdata[m_owner] = m_mem[m_addr[4:0]];
      m_left = 1;
    end else begin
      m_left = 0;
    end
  endtask

  task automatic check_outputs();
    check_eq("busy", 32'(busy), 32'(m_left != 0));
    check_eq("mem_write", 32'(mem_write), 32'(m_left == 2 && m_we));
    check_eq("mem_read", 32'(mem_read), 32'(m_left == 2 && !m_we));
    check_eq("r0_ack", 32'(r0_ack), 32'(m_left == 1 && !m_owner));
    check_eq("r1_ack", 32'(r1_ack), 32'(m_left == 1 && m_owner));
    check_eq("owner", 32'(owner), 32'(m_owner));
    check_eq("mem_addr", mem_addr, m_addr);
    check_eq("mem_wdata", mem_wdata, m_wdata);
    check_eq("r0_rdata", r0_rdata, m_rdata[0]);
    check_eq("r1_rdata", r1_rdata, m_rdata[1]);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input int p, input bit req, input bit we, input bit [31:0] a,
                       input bit [31:0] d);
    if (p == 0) begin
      r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    end
  endtask

  // Single transaction from an idle arbiter; returns to idle before exiting.
  task automatic txn(input int p, input bit we, input bit [31:0] a, input bit [31:0] d);
    int  n;
    bit  got;
    drive(p, 1'b1, we, a, d);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      cyc();
      n++;
      got = (p == 0) ? r0_ack : r1_ack;
    end
    check_eq("txn_latency", 32'(n), 32'd2);
    drive(p, 1'b0, 1'b0, '0, '0);
    cyc();
  endtask

  int        ack_cyc [$];
  int        ack_port [$];
  bit        act [2];
  bit [31:0] saved;

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_reset();
    @(negedge clk);
    check_outputs();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Contention straight after reset: port 0 first, then strict alternation.
    drive(0, 1'b1, 1'b1, 32'h10, 32'h1111_1111);
    drive(1, 1'b1, 1'b0, 32'h1F, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (r0_ack) begin ack_cyc.push_back(c); ack_port.push_back(0); end
      if (r1_ack) begin
        ack_cyc.push_back(c); ack_port.push_back(1);
        check_eq("r1_rdata_contention", r1_rdata, 32'h0);
      end
    end
    check_eq("contention_ack_count", 32'(ack_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
      check_eq("contention_ack_cycle", 32'(ack_cyc[i]), 32'(2 + 3 * i));
      check_eq("contention_ack_port", 32'(ack_port[i]), 32'(i % 2));
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    cyc();

    // Port 0 write then read back.
    txn(0, 1'b1, 32'h4, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h4, 32'h0);
    check_eq("r0_readback", r0_rdata, 32'hDEAD_BEEF);

    // Port 1 read isolation.
    txn(0, 1'b1, 32'h1F, 32'hA5A5_A5A5);
    saved = r0_rdata;
    txn(1, 1'b0, 32'h1F, 32'h0);
    check_eq("r1_isolated_read", r1_rdata, 32'hA5A5_A5A5);
    check_eq("r0_rdata_kept", r0_rdata, saved);

    // Reset during the memory-access cycle of a write.
    drive(0, 1'b1, 1'b1, 32'h8, 32'h1234_5678);
    cyc();
    check_eq("pre_reset_write", 32'(mem_write), 32'd1);
    drive(0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("reset_drops_write", 32'(mem_write), 32'd0);
    check_outputs();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    txn(0, 1'b0, 32'h8, 32'h0);
    check_eq("aborted_write_absent", r0_rdata, 32'h0);

    // Back-to-back port 1 reads with req held high.
    ack_cyc.delete();
    drive(1, 1'b1, 1'b0, 32'h1F, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (r1_ack) ack_cyc.push_back(c);
    end
    check_eq("b2b_ack_count", 32'(ack_cyc.size()), 32'd3);
    for (int i = 0; i < 3 && i < ack_cyc.size(); i++) begin
      check_eq("b2b_ack_cycle", 32'(ack_cyc[i]), 32'(2 + 3 * i));
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    cyc();

    // Random traffic; each requester keeps its request stable until acked.
    act[0] = 1'b0;
    act[1] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (act[p] && ((p == 0) ? r0_ack : r1_ack)) act[p] = 1'b0;
        if (!act[p]) begin
          if ($urandom_range(0, 1) == 1) begin
            act[p] = 1'b1;
            drive(p, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
          end else begin
            drive(p, 1'b0, 1'b0, '0, '0);
          end
        end
      end
      cyc();
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
